// File: rtl/scs8hd_cplx_gate_bist.sv
// scs8hd_cplx_gate_bist: BIST sequencer sweeping all 16 vectors through an o22ai/a22oi-family gate
// and checking its readback.
module scs8hd_cplx_gate_bist #(
    parameter int FUNC   = 0,
    parameter int SETTLE = 2,
    parameter int PASSES = 1,
    parameter int ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             START,
    input  logic             ABORT,
    input  logic             Y,
    output logic             A1,
    output logic             A2,
    output logic             B1,
    output logic             B2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [3:0]       FAIL_VEC
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, FIN} state_t;
    localparam logic [3:0] WLAST = SETTLE == 0 ? 4'd0 : 4'(SETTLE - 1);
    state_t state;
    logic [3:0] idx, cnt, pins, vec;
    logic [2:0] pass;
    logic o22, a22, exp_y, mis, last;
    assign pins  = {A1, A2, B1, B2};
    // odd passes walk the vectors downwards so both transition directions are exercised
    assign vec   = pass[0] ? ~idx : idx;
    assign o22   = (pins[3] | pins[2]) & (pins[1] | pins[0]);
    assign a22   = (pins[3] & pins[2]) | (pins[1] & pins[0]);
    assign exp_y = FUNC == 0 ? ~o22 : FUNC == 1 ? ~a22 : FUNC == 2 ? o22 : a22;
    assign mis   = Y !== exp_y;
    assign last  = idx == 4'd15 && pass == 3'(PASSES - 1);
    always_ff @(posedge CLK) begin
        if (!RESETB) begin
            state <= IDLE;
            {A1, A2, B1, B2} <= 4'd0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
            ERR_CNT <= '0;
            FAIL_VALID <= 1'b0;
            FAIL_VEC <= 4'd0;
            idx <= 4'd0;
            pass <= 3'd0;
            cnt <= 4'd0;
        end else if (state != IDLE && ABORT) begin
            state <= IDLE;
            {A1, A2, B1, B2} <= 4'd0;
            BUSY <= 1'b0;
            DONE <= 1'b0;
            PASS <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START && !ABORT) begin
                    state <= DRIVE;
                    BUSY <= 1'b1;
                    DONE <= 1'b0;
                    PASS <= 1'b0;
                    ERR_CNT <= '0;
                    FAIL_VALID <= 1'b0;
                    FAIL_VEC <= 4'd0;
                    idx <= 4'd0;
                    pass <= 3'd0;
                end
                DRIVE: begin
                    {A1, A2, B1, B2} <= vec;
                    cnt <= 4'd0;
                    state <= SETTLE == 0 ? SAMPLE : WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == WLAST) state <= SAMPLE;
                end
                SAMPLE: begin
                    if (mis) begin
                        if (ERR_CNT != '1) ERR_CNT <= ERR_CNT + ERR_W'(1);
                        if (!FAIL_VALID) begin
                            FAIL_VALID <= 1'b1;
                            FAIL_VEC <= pins;
                        end
                    end
                    idx <= idx + 4'd1;
                    if (idx == 4'd15) pass <= pass + 3'd1;
                    if (last) begin
                        state <= FIN;
                        BUSY <= 1'b0;
                        DONE <= 1'b1;
                        PASS <= ERR_CNT == '0 && !mis;
                        {A1, A2, B1, B2} <= 4'd0;
                    end else begin
                        state <= DRIVE;
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scs8hd_cplx_gate_bist.sv
// tb_scs8hd_cplx_gate_bist: two BIST instances (o22ai/settle 2/1 pass, a22oi/settle 0/2 passes, 3-bit count)
// driven with directed and randomized gate faults against a run-level reference model.
module tb_scs8hd_cplx_gate_bist;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstb, st0, st1, ab0, ab1, y0, y1;
    logic bsy0, bsy1, dn0, dn1, ps0, ps1, fv0, fv1;
    logic [3:0] p0, p1, fvec0, fvec1;
    logic [7:0] e0;
    logic [2:0] e1;
    int mode[2];
    logic [15:0] mask[2];
    int n_chk = 0, n_fail = 0;

    scs8hd_cplx_gate_bist #(.FUNC(0), .SETTLE(2), .PASSES(1), .ERR_W(8)) d0 (
        .CLK(clk), .RESETB(rstb), .START(st0), .ABORT(ab0), .Y(y0),
        .A1(p0[3]), .A2(p0[2]), .B1(p0[1]), .B2(p0[0]),
        .BUSY(bsy0), .DONE(dn0), .PASS(ps0), .ERR_CNT(e0), .FAIL_VALID(fv0), .FAIL_VEC(fvec0));
    scs8hd_cplx_gate_bist #(.FUNC(1), .SETTLE(0), .PASSES(2), .ERR_W(3)) d1 (
        .CLK(clk), .RESETB(rstb), .START(st1), .ABORT(ab1), .Y(y1),
        .A1(p1[3]), .A2(p1[2]), .B1(p1[1]), .B2(p1[0]),
        .BUSY(bsy1), .DONE(dn1), .PASS(ps1), .ERR_CNT(e1), .FAIL_VALID(fv1), .FAIL_VEC(fvec1));

    // ideal gate from its Boolean definition on the pin pairs
    function automatic logic gate(input int f, input logic [3:0] v);
        int hi = int'(v) / 4;
        int lo = int'(v) % 4;
        bit o = hi != 0 && lo != 0;
        bit a = hi == 3 || lo == 3;
        return f == 0 ? !o : f == 1 ? !a : f == 2 ? o : a;
    endfunction
    // modes: 0 ideal, 1 stuck-1, 2 stuck-0, 3 ideal with per-vector flips from mask
    function automatic logic ymod(input int m, input logic [15:0] k, input int f, input logic [3:0] v);
        return m == 0 ? gate(f, v) : m == 1 ? 1'b1 : m == 2 ? 1'b0 : gate(f, v) ^ k[v];
    endfunction
    always_comb begin
        y0 = ymod(mode[0], mask[0], 0, p0);
        y1 = ymod(mode[1], mask[1], 1, p1);
    end

    function automatic logic [31:0] g_busy(input int d); return d != 0 ? 32'(bsy1) : 32'(bsy0); endfunction
    function automatic logic [31:0] g_done(input int d); return d != 0 ? 32'(dn1) : 32'(dn0); endfunction
    function automatic logic [31:0] g_pass(input int d); return d != 0 ? 32'(ps1) : 32'(ps0); endfunction
    function automatic logic [31:0] g_pins(input int d); return d != 0 ? 32'(p1) : 32'(p0); endfunction
    function automatic logic [31:0] g_err(input int d); return d != 0 ? 32'(e1) : 32'(e0); endfunction
    function automatic logic [31:0] g_fv(input int d); return d != 0 ? 32'(fv1) : 32'(fv0); endfunction
    function automatic logic [31:0] g_fvec(input int d); return d != 0 ? 32'(fvec1) : 32'(fvec0); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int d, input logic v);
        if (d != 0) st1 = v; else st0 = v;
    endtask
    task automatic set_abort(input int d, input logic v);
        if (d != 0) ab1 = v; else ab0 = v;
    endtask

    // one run: model the expected sweep, then follow it edge by edge until the stop edge
    task automatic run(input int d, input int m, input logic [15:0] mk, input int abort_at,
                       input int reset_at, input bit spam, input string tag);
        int s = d != 0 ? 0 : 2;
        int pp = d != 0 ? 2 : 1;
        int w = d != 0 ? 3 : 8;
        int f = d != 0 ? 1 : 0;
        int per = s + 2;
        int n = pp * 16 * per;
        int stop = abort_at > 0 ? abort_at : reset_at > 0 ? reset_at : n;
        bit normal = abort_at == 0 && reset_at == 0;
        logic [3:0] ord[$];
        int errs = 0, sat;
        bit have = 0;
        logic [3:0] first = 4'd0;
        for (int p = 0; p < pp; p++)
            for (int i = 0; i < 16; i++) ord.push_back(4'(p % 2 == 1 ? 15 - i : i));
        for (int j = 0; j < ord.size(); j++)
            if (normal || per * (j + 1) < stop)
                if (ymod(m, mk, f, ord[j]) !== gate(f, ord[j])) begin
                    errs++;
                    if (!have) begin have = 1; first = ord[j]; end
                end
        sat = errs > (1 << w) - 1 ? (1 << w) - 1 : errs;
        mode[d] = m;
        mask[d] = mk;
        @(negedge clk);
        set_start(d, 1'b1);
        @(posedge clk);
        #1 set_start(d, 1'b0);
        for (int k = 0; k <= stop; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == stop) begin set_abort(d, 1'b0); rstb = 1'b1; end
            if (k < stop) begin
                chk({tag, "_busy"}, g_busy(d), 1);
                chk({tag, "_pins"}, g_pins(d), k == 0 ? 0 : 32'(ord[(k - 1) / per]));
                if (k == 0) begin
                    chk({tag, "_clr_err"}, g_err(d), 0);
                    chk({tag, "_clr_done"}, g_done(d), 0);
                end
            end
            if (spam && k == 10) set_start(d, 1'b1);
            if (spam && k == 11) set_start(d, 1'b0);
            if (k == stop - 1 && abort_at > 0) set_abort(d, 1'b1);
            if (k == stop - 1 && reset_at > 0) rstb = 1'b0;
        end
        chk({tag, "_end_busy"}, g_busy(d), 0);
        chk({tag, "_end_pins"}, g_pins(d), 0);
        chk({tag, "_end_done"}, g_done(d), normal ? 1 : 0);
        chk({tag, "_end_pass"}, g_pass(d), normal && errs == 0 ? 1 : 0);
        chk({tag, "_err"}, g_err(d), reset_at > 0 ? 0 : 32'(sat));
        chk({tag, "_fv"}, g_fv(d), reset_at > 0 ? 0 : 32'(have));
        chk({tag, "_fvec"}, g_fvec(d), reset_at > 0 ? 0 : 32'(first));
        @(posedge clk);
        #1 chk({tag, "_after_busy"}, g_busy(d), 0);
        chk({tag, "_after_done"}, g_done(d), normal ? 1 : 0);
    endtask

    initial begin
        rstb = 1'b0;
        {st0, st1, ab0, ab1} = 4'd0;
        mode[0] = 0; mode[1] = 0;
        mask[0] = 16'd0; mask[1] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", g_busy(d), 0);
            chk("rst_done", g_done(d), 0);
            chk("rst_pass", g_pass(d), 0);
            chk("rst_pins", g_pins(d), 0);
            chk("rst_err", g_err(d), 0);
            chk("rst_fv", g_fv(d), 0);
            chk("rst_fvec", g_fvec(d), 0);
        end
        rstb = 1'b1;
        run(0, 0, 16'd0, 0, 0, 0, "ideal");
        run(0, 1, 16'd0, 0, 0, 0, "stuck1");
        run(1, 1, 16'd0, 0, 0, 0, "a22_stuck1");
        run(1, 2, 16'd0, 0, 0, 0, "a22_stuck0");
        run(0, 2, 16'd0, 20, 0, 0, "abort");
        @(negedge clk);
        st0 = 1'b1; ab0 = 1'b1;
        @(posedge clk);
        #1 st0 = 1'b0; ab0 = 1'b0;
        chk("start_abort_busy", g_busy(0), 0);
        chk("start_abort_err_held", g_err(0), 4);
        chk("start_abort_fv_held", g_fv(0), 1);
        @(posedge clk);
        #1 chk("start_abort_idle", g_busy(0), 0);
        run(0, 0, 16'd0, 0, 0, 0, "fresh");
        run(0, 1, 16'd0, 0, 30, 0, "reset");
        run(0, 0, 16'd0, 0, 0, 1, "spam");
        for (int i = 0; i < 6; i++) run(i % 2, 3, 16'($urandom), 0, 0, 0, "rand");
        run(0, 3, 16'($urandom), $urandom_range(5, 60), 0, 0, "rand_abort");
        run(1, 3, 16'($urandom), $urandom_range(3, 30), 0, 0, "rand_abort1");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
